pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline controller. Generates the 2-bit stall code (`STALL_NEXT/`STALL_KEEP/`STALL_ZERO,
//  from defines.v) consumed by the PC register and the if_id, id_ex, ex_mem and mem_wb stage registers.
//  Resolves memory-busy freezes, load-use bubbles, fetch-busy bubbles and EX-stage redirects.
//  Tracks the fetch that is in flight during a redirect so its late return is squashed.
//  Keeps stall and flush performance counters.
// PARAMETERS
//  CNT_W  64  width of stall_cycles / flush_count counters (wrap at 2^CNT_W)
// PORTS
//  clk           in   1      single clock; all state on posedge
//  rst           in   1      reset, asynchronous, active-low
//  id_rs1_ren    in   1      ID instruction reads rs1
//  id_rs2_ren    in   1      ID instruction reads rs2
//  id_rs1_addr   in   5      ID rs1 index
//  id_rs2_addr   in   5      ID rs2 index
//  ex_mem_rena   in   1      EX instruction is a load
//  ex_rd_waddr   in   5      EX destination index
//  ex_redirect   in   1      EX resolved a taken branch or jump (PC must load target)
//  if_busy       in   1      fetch outstanding; no instruction delivered this cycle
//  if_done       in   1      fetch response returns this cycle
//  mem_busy      in   1      MEM data access outstanding
//  stall_pc      out  2      PC register code (only NEXT/KEEP driven)
//  stall_if_id   out  2      if_id code
//  stall_id_ex   out  2      id_ex code
//  stall_ex_mem  out  2      ex_mem code
//  stall_mem_wb  out  2      mem_wb code
//  stall_cycles  out  CNT_W  cycles in which stall_pc == KEEP
//  flush_count   out  CNT_W  accepted redirects
// BEHAVIOUR
//  Stall codes are combinational from the inputs and state (same-cycle effect). Counters and state are registered.
//  Reset (rst==0): state=RUN and counters=0 asynchronously. While rst is low, stall_pc=KEEP and all stage codes=ZERO.
//  load_use = ex_mem_rena & ex_rd_waddr!=0 & ((id_rs1_ren & rs1==rd) | (id_rs2_ren & rs2==rd)).
//  Priority (first match wins); each case lists pc/if_id/id_ex/ex_mem/mem_wb:
//   1 mem_busy           : KEEP/KEEP/KEEP/KEEP/ZERO. Redirect is ignored; EX holds it, so it re-presents later.
//   2 ex_redirect        : NEXT/ZERO/ZERO/NEXT/NEXT. flush_count+1 (accepted redirect only).
//   3 load_use           : KEEP/KEEP/ZERO/NEXT/NEXT. Exactly one bubble; next cycle the load is in MEM.
//   4 if_busy & !if_done : KEEP/ZERO/NEXT/NEXT/NEXT.
//   5 otherwise          : all NEXT. In state DROP with if_done, if_id=ZERO instead.
//  FSM states RUN and DROP.
//   RUN->DROP: on an accepted redirect (case 2) while if_busy & !if_done, the in-flight fetch is wrong-path.
//   DROP, if_done & !mem_busy: if_id forced ZERO; the returned word is discarded; go to RUN.
//   DROP, if_done coincident with another accepted redirect: squash; stay in DROP only if if_busy & !if_done.
//   DROP, if_done while mem_busy: stay in DROP. The frontend holds its response until mem_busy drops.
//   Redirect in the same cycle as if_done: case 2 flushes the word; no DROP entry.
//  stall_cycles += 1 on every cycle with stall_pc==KEEP, excluding reset.
//  Counters wrap modulo 2^CNT_W.
//  Async reset mid-DROP returns to RUN. The fetch unit's own reset discards its outstanding request.
// STRUCTURE
//  Stall encodings stay in defines.v; add PCTRL_RUN / PCTRL_DROP state defines there.
//  One sub-module is natural: hazard_detect (combinational load_use compare), instanced once.
//  Priority mux, FSM and counters live in pipe_ctrl.
// TESTING
//  1 Reset low 3 cycles -> stall_pc=KEEP, stage codes ZERO, counters 0. Release -> all NEXT.
//  2 ex_mem_rena=1, rd=5, id_rs1_ren=1, rs1=5, one cycle -> pc/if_id KEEP, id_ex ZERO for exactly 1 cycle; stall_cycles=1.
//  3 Same as 2 with rd=0 -> all NEXT; stall_cycles stays 0.
//  4 ex_redirect with if_busy=1 -> if_id/id_ex ZERO, flush_count=1. if_done 4 cycles later -> if_id ZERO that cycle only. Next fetch -> NEXT.
//  5 mem_busy and ex_redirect together for 3 cycles -> freeze pattern, flush_count 0. mem_busy drops -> redirect accepted, flush_count=1.
//  6 ex_redirect and if_done in the same cycle -> state remains RUN; the following if_done passes NEXT.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: stall encodings, FSM states and
// the bundled per-stage stall vector.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    STALL_NEXT = 2'b00,
    STALL_KEEP = 2'b01,
    STALL_ZERO = 2'b10
  } stall_e;

  typedef enum logic {
    PCTRL_RUN  = 1'b0,
    PCTRL_DROP = 1'b1
  } pctrl_state_e;

  typedef struct packed {
    stall_e pc;
    stall_e if_id;
    stall_e id_ex;
    stall_e ex_mem;
    stall_e mem_wb;
  } stall_vec_t;

  function automatic stall_vec_t mk_codes(input stall_e pc, input stall_e if_id,
                                          input stall_e id_ex, input stall_e ex_mem,
                                          input stall_e mem_wb);
    stall_vec_t v;
    v.pc     = pc;
    v.if_id  = if_id;
    v.id_ex  = id_ex;
    v.ex_mem = ex_mem;
    v.mem_wb = mem_wb;
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline and its controller.
// if_busy means a fetch is outstanding; if_done pulses for the one cycle its word returns.
interface pipe_ctrl_if #(parameter int CNT_W = 64);
  import pipe_ctrl_pkg::*;

  logic         id_rs1_ren;
  logic         id_rs2_ren;
  logic [4:0]   id_rs1_addr;
  logic [4:0]   id_rs2_addr;
  logic         ex_mem_rena;
  logic [4:0]   ex_rd_waddr;
  logic         ex_redirect;
  logic         if_busy;
  logic         if_done;
  logic         mem_busy;
  stall_e       stall_pc;
  stall_e       stall_if_id;
  stall_e       stall_id_ex;
  stall_e       stall_ex_mem;
  stall_e       stall_mem_wb;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  pctrl_state_e dbg_state;

  modport master (
    output id_rs1_ren, id_rs2_ren, id_rs1_addr, id_rs2_addr,
           ex_mem_rena, ex_rd_waddr, ex_redirect, if_busy, if_done, mem_busy,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
           stall_cycles, flush_count, dbg_state
  );

  modport slave (
    input  id_rs1_ren, id_rs2_ren, id_rs1_addr, id_rs2_addr,
           ex_mem_rena, ex_rd_waddr, ex_redirect, if_busy, if_done, mem_busy,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
           stall_cycles, flush_count, dbg_state
  );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the ID instruction.
module pipe_ctrl_hazard_detect (
  input  logic       id_rs1_ren_i,
  input  logic       id_rs2_ren_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       ex_mem_rena_i,
  input  logic [4:0] ex_rd_waddr_i,
  output logic       load_use_o
);
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = id_rs1_ren_i && (id_rs1_addr_i == ex_rd_waddr_i);
  assign rs2_hit    = id_rs2_ren_i && (id_rs2_addr_i == ex_rd_waddr_i);
  // x0 is never written, so a load targeting it cannot create a dependency.
  assign load_use_o = ex_mem_rena_i && (ex_rd_waddr_i != 5'd0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: priority stall mux, wrong-path fetch tracking FSM and
// stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave ctrl
);

  logic             load_use;
  logic             redirect_acc;
  stall_vec_t       codes;
  pctrl_state_e     state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  pipe_ctrl_hazard_detect u_hazard (
    .id_rs1_ren_i  (ctrl.id_rs1_ren),
    .id_rs2_ren_i  (ctrl.id_rs2_ren),
    .id_rs1_addr_i (ctrl.id_rs1_addr),
    .id_rs2_addr_i (ctrl.id_rs2_addr),
    .ex_mem_rena_i (ctrl.ex_mem_rena),
    .ex_rd_waddr_i (ctrl.ex_rd_waddr),
    .load_use_o    (load_use)
  );

  always_comb begin
    codes        = mk_codes(STALL_NEXT, STALL_NEXT, STALL_NEXT, STALL_NEXT, STALL_NEXT);
    state_d      = state_q;
    redirect_acc = 1'b0;
    if (!rst) begin
      codes = mk_codes(STALL_KEEP, STALL_ZERO, STALL_ZERO, STALL_ZERO, STALL_ZERO);
    end else if (ctrl.mem_busy) begin
      // Full freeze; a pending redirect stays in EX and is taken once MEM frees up.
      codes = mk_codes(STALL_KEEP, STALL_KEEP, STALL_KEEP, STALL_KEEP, STALL_ZERO);
    end else if (ctrl.ex_redirect) begin
      codes        = mk_codes(STALL_NEXT, STALL_ZERO, STALL_ZERO, STALL_NEXT, STALL_NEXT);
      redirect_acc = 1'b1;
      state_d      = (ctrl.if_busy && !ctrl.if_done) ? PCTRL_DROP : PCTRL_RUN;
    end else if (load_use) begin
      codes = mk_codes(STALL_KEEP, STALL_KEEP, STALL_ZERO, STALL_NEXT, STALL_NEXT);
      // A wrong-path word returning now is not captured because if_id holds.
      if (state_q == PCTRL_DROP && ctrl.if_done) state_d = PCTRL_RUN;
    end else if (ctrl.if_busy && !ctrl.if_done) begin
      codes = mk_codes(STALL_KEEP, STALL_ZERO, STALL_NEXT, STALL_NEXT, STALL_NEXT);
    end else if (state_q == PCTRL_DROP && ctrl.if_done) begin
      codes.if_id = STALL_ZERO;
      state_d     = PCTRL_RUN;
    end

    stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, (codes.pc == STALL_KEEP)};
    flush_count_d  = flush_count_q + {{(CNT_W-1){1'b0}}, redirect_acc};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= PCTRL_RUN;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign ctrl.stall_pc     = codes.pc;
  assign ctrl.stall_if_id  = codes.if_id;
  assign ctrl.stall_id_ex  = codes.id_ex;
  assign ctrl.stall_ex_mem = codes.ex_mem;
  assign ctrl.stall_mem_wb = codes.mem_wb;
  assign ctrl.stall_cycles = stall_cycles_q;
  assign ctrl.flush_count  = flush_count_q;
  assign ctrl.dbg_state    = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall-code priority, wrong-path squash FSM and counters.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 64;
  localparam logic [1:0] N = STALL_NEXT;
  localparam logic [1:0] K = STALL_KEEP;
  localparam logic [1:0] Z = STALL_ZERO;
  localparam logic [9:0] ALL_NEXT = {N, N, N, N, N};
  localparam logic [9:0] FREEZE   = {K, K, K, K, Z};
  localparam logic [9:0] REDIR    = {N, Z, Z, N, N};
  localparam logic [9:0] LDUSE    = {K, K, Z, N, N};
  localparam logic [9:0] FBUSY    = {K, Z, N, N, N};
  localparam logic [9:0] SQUASH   = {N, Z, N, N, N};
  localparam logic [9:0] RESET_V  = {K, Z, Z, Z, Z};

  logic clk = 1'b0;
  logic rst = 1'b0;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  always #5 clk = ~clk;

  logic [9:0]       exp_q[$];
  int               vectors     = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] exp_stall   = '0;
  logic [CNT_W-1:0] exp_flush   = '0;

  function automatic logic [9:0] got_codes();
    return {bus.stall_pc, bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_mem, bus.stall_mem_wb};
  endfunction

  task automatic idle();
    bus.id_rs1_ren  = 1'b0;
    bus.id_rs2_ren  = 1'b0;
    bus.id_rs1_addr = 5'd0;
    bus.id_rs2_addr = 5'd0;
    bus.ex_mem_rena = 1'b0;
    bus.ex_rd_waddr = 5'd0;
    bus.ex_redirect = 1'b0;
    bus.if_busy     = 1'b0;
    bus.if_done     = 1'b0;
    bus.mem_busy    = 1'b0;
  endtask

  task automatic check_now(input logic [9:0] e, input string tag);
    logic [9:0] want;
    exp_q.push_back(e);
    #1;
    want = exp_q.pop_front();
    vectors++;
    assert (got_codes() === want) else begin
      miscompares++;
      $error("FAIL %s codes got=%h want=%h", tag, got_codes(), want);
    end
  endtask

  task automatic check_cnt(input string tag);
    vectors++;
    assert (bus.stall_cycles === exp_stall) else begin
      miscompares++;
      $error("FAIL %s stall_cycles got=%0d want=%0d", tag, bus.stall_cycles, exp_stall);
    end
    vectors++;
    assert (bus.flush_count === exp_flush) else begin
      miscompares++;
      $error("FAIL %s flush_count got=%0d want=%0d", tag, bus.flush_count, exp_flush);
    end
  endtask

  task automatic check_state(input pctrl_state_e e, input string tag);
    vectors++;
    assert (bus.dbg_state === e) else begin
      miscompares++;
      $error("FAIL %s state got=%0d want=%0d", tag, bus.dbg_state, e);
    end
  endtask

  // Check the current-cycle codes, then clock once and check the counters.
  task automatic cycle(input logic [9:0] e, input string tag);
    check_now(e, tag);
    if (e[9:8] == K) exp_stall++;
    if (bus.ex_redirect && !bus.mem_busy) exp_flush++;
    @(posedge clk);
    #1;
    check_cnt(tag);
  endtask

  initial begin
    logic [9:0] want;
    idle();
    // Reset held for three cycles
    repeat (3) begin
      @(posedge clk);
      #1;
      check_now(RESET_V, "reset_codes");
      check_cnt("reset_cnt");
      check_state(PCTRL_RUN, "reset_state");
    end
    rst = 1'b1;
    cycle(ALL_NEXT, "release");

    // Load-use on rs1 gives exactly one bubble
    bus.ex_mem_rena = 1'b1; bus.ex_rd_waddr = 5'd5;
    bus.id_rs1_ren  = 1'b1; bus.id_rs1_addr = 5'd5;
    cycle(LDUSE, "load_use_rs1");
    idle();
    cycle(ALL_NEXT, "after_bubble");

    // Load to x0 is not a hazard
    bus.ex_mem_rena = 1'b1; bus.ex_rd_waddr = 5'd0;
    bus.id_rs1_ren  = 1'b1; bus.id_rs1_addr = 5'd0;
    cycle(ALL_NEXT, "load_x0");
    idle();

    // Load-use on rs2, and rs2 match without its read enable
    bus.ex_mem_rena = 1'b1; bus.ex_rd_waddr = 5'd9;
    bus.id_rs2_ren  = 1'b1; bus.id_rs2_addr = 5'd9;
    cycle(LDUSE, "load_use_rs2");
    bus.id_rs2_ren  = 1'b0;
    cycle(ALL_NEXT, "rs2_not_read");
    idle();

    // Random load-use patterns over a small register range
    for (int i = 0; i < 8; i++) begin
      bus.ex_mem_rena = 1'($urandom_range(0, 1));
      bus.ex_rd_waddr = 5'($urandom_range(0, 3));
      bus.id_rs1_ren  = 1'($urandom_range(0, 1));
      bus.id_rs2_ren  = 1'($urandom_range(0, 1));
      bus.id_rs1_addr = 5'($urandom_range(0, 3));
      bus.id_rs2_addr = 5'($urandom_range(0, 3));
      want = (bus.ex_mem_rena && bus.ex_rd_waddr != 5'd0 &&
              ((bus.id_rs1_ren && bus.id_rs1_addr == bus.ex_rd_waddr) ||
               (bus.id_rs2_ren && bus.id_rs2_addr == bus.ex_rd_waddr))) ? LDUSE : ALL_NEXT;
      cycle(want, "rand_hazard");
    end
    idle();

    // Redirect with a fetch in flight, late return squashed
    bus.ex_redirect = 1'b1; bus.if_busy = 1'b1;
    cycle(REDIR, "redir_busy");
    check_state(PCTRL_DROP, "enter_drop");
    idle(); bus.if_busy = 1'b1;
    repeat (3) cycle(FBUSY, "drop_wait");
    bus.if_busy = 1'b0; bus.if_done = 1'b1;
    cycle(SQUASH, "drop_squash");
    check_state(PCTRL_RUN, "drop_exit");
    cycle(ALL_NEXT, "next_fetch");
    idle();

    // Late return during mem_busy waits in DROP
    bus.ex_redirect = 1'b1; bus.if_busy = 1'b1;
    cycle(REDIR, "redir_busy2");
    idle(); bus.mem_busy = 1'b1; bus.if_done = 1'b1;
    cycle(FREEZE, "drop_membusy");
    check_state(PCTRL_DROP, "drop_hold");
    bus.mem_busy = 1'b0;
    cycle(SQUASH, "drop_squash2");
    check_state(PCTRL_RUN, "drop_exit2");
    idle();

    // Redirects while already in DROP
    bus.ex_redirect = 1'b1; bus.if_busy = 1'b1;
    cycle(REDIR, "redir_busy3");
    cycle(REDIR, "redir_in_drop");
    check_state(PCTRL_DROP, "drop_rearm");
    bus.if_done = 1'b1;
    cycle(REDIR, "redir_done_in_drop");
    check_state(PCTRL_RUN, "drop_redir_exit");
    idle();

    // mem_busy masks a redirect until it drops
    bus.mem_busy = 1'b1; bus.ex_redirect = 1'b1;
    repeat (3) cycle(FREEZE, "membusy_redir");
    bus.mem_busy = 1'b0;
    cycle(REDIR, "redir_after_mem");
    check_state(PCTRL_RUN, "redir_no_fetch");
    idle();

    // Priority: mem_busy over load-use, load-use over fetch-busy, redirect over load-use
    bus.ex_mem_rena = 1'b1; bus.ex_rd_waddr = 5'd3;
    bus.id_rs1_ren  = 1'b1; bus.id_rs1_addr = 5'd3;
    bus.mem_busy = 1'b1;
    cycle(FREEZE, "prio_mem_lu");
    bus.mem_busy = 1'b0; bus.if_busy = 1'b1;
    cycle(LDUSE, "prio_lu_fbusy");
    bus.if_busy = 1'b0; bus.ex_redirect = 1'b1;
    cycle(REDIR, "prio_redir_lu");
    idle();

    // Redirect coincident with the fetch return: no DROP
    bus.ex_redirect = 1'b1; bus.if_busy = 1'b1; bus.if_done = 1'b1;
    cycle(REDIR, "redir_with_done");
    check_state(PCTRL_RUN, "no_drop");
    idle(); bus.if_done = 1'b1;
    cycle(ALL_NEXT, "done_passes");
    idle();

    // Async reset in the middle of DROP
    bus.ex_redirect = 1'b1; bus.if_busy = 1'b1;
    cycle(REDIR, "redir_busy4");
    idle(); bus.if_busy = 1'b1;
    rst = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
    check_now(RESET_V, "async_rst_codes");
    check_cnt("async_rst_cnt");
    check_state(PCTRL_RUN, "async_rst_state");
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    cycle(ALL_NEXT, "post_reset");

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
